// File: rtl/if_stage_pkg.sv
// Shared constants and payload types for the instruction fetch stage.
package if_stage_pkg;

  localparam int unsigned WORD = 32;
  localparam int unsigned ST_W = 2;

  // Fetch controller state encoding
  localparam logic [ST_W-1:0] ST_FETCH = 2'd0;
  localparam logic [ST_W-1:0] ST_HOLD  = 2'd1;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [ST_W-1:0] ST_HALT  = 2'd3;

  localparam logic [WORD-1:0] NOP      = 32'h0000_0000;
  localparam logic [WORD-1:0] RESET_PC = 32'h0000_0000;

  // One IF/ID entry: fetched word and the address following it
  typedef struct packed {
    logic [WORD-1:0] instr;
    logic [WORD-1:0] pc_plus4;
  } ifid_t;

endpackage

// File: rtl/if_stage_pc_target_calc.sv
// Redirect target for a taken branch or jump, relative to the IF/ID pc_plus4.
module pc_target_calc
  import if_stage_pkg::*;
(
  input  logic [WORD-1:0] pc_plus4,
  input  logic [15:0]     branch_offset,
  input  logic [25:0]     jump_index,
  input  logic            jump_taken,
  output logic [WORD-1:0] target_c
);

  logic [WORD-1:0] branch_target_c;
  logic [WORD-1:0] jump_target_c;

  // Jump wins over branch when both are resolved in the same cycle
  always_comb begin
    branch_target_c = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    jump_target_c   = {pc_plus4[31:28], jump_index, 2'b00};
    target_c        = jump_taken ? jump_target_c : branch_target_c;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, the memory request and the IF/ID register.
module if_stage
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            jump_taken,
  input  logic [31:0]     branch_offset,
  input  logic [31:0]     jump_address,
  input  logic            terminate,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instruction,
  output logic [31:0]     pc_plus4,
  output logic            valid,
  output logic            halted
);

  logic [ST_W-1:0] state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  ifid_t           ifid_q, ifid_d;
  logic            valid_q, valid_d;
  ifid_t           buf_q, buf_d;
  logic            halt_pend_q, halt_pend_d;
  logic            req_q, req_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic            halted_q, halted_d;

  logic            ack_c;
  logic            term_c;
  logic            redirect_c;
  logic [WORD-1:0] pc_inc_c;
  logic [WORD-1:0] target_c;
  logic            unused_hi_c;

  // An ack with no request of ours outstanding (e.g. just after reset) is ignored
  assign ack_c       = imem_ack & req_q;
  assign term_c      = terminate & ~stall;
  assign redirect_c  = (jump_taken | branch_taken) & ~stall;
  assign pc_inc_c    = pc_q + WORD'(4);
  assign unused_hi_c = ^{branch_offset[31:16], jump_address[31:26]};

  pc_target_calc u_target (
    .pc_plus4      (ifid_q.pc_plus4),
    .branch_offset (branch_offset[15:0]),
    .jump_index    (jump_address[25:0]),
    .jump_taken    (jump_taken),
    .target_c      (target_c)
  );

  // Next state and next register contents; priority terminate > redirect > stall > normal
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_d      = ifid_q;
    valid_d     = valid_q;
    buf_d       = buf_q;
    halt_pend_d = halt_pend_q;

    case (state_q)
      ST_FETCH: begin
        if (term_c) begin
          ifid_d.instr = NOP;
          valid_d      = 1'b0;
          if (req_q & ~ack_c) begin
            state_d     = ST_DRAIN;
            halt_pend_d = 1'b1;
          end else begin
            state_d = ST_HALT;
          end
        end else if (redirect_c) begin
          pc_d         = target_c;
          ifid_d.instr = NOP;
          valid_d      = 1'b0;
          if (req_q & ~ack_c) state_d = ST_DRAIN;
        end else if (stall) begin
          if (ack_c) begin
            buf_d.instr    = imem_rdata;
            buf_d.pc_plus4 = pc_inc_c;
            pc_d           = pc_inc_c;
            state_d        = ST_HOLD;
          end
        end else if (ack_c) begin
          ifid_d.instr    = imem_rdata;
          ifid_d.pc_plus4 = pc_inc_c;
          valid_d         = 1'b1;
          pc_d            = pc_inc_c;
        end else begin
          ifid_d.instr = NOP;
          valid_d      = 1'b0;
        end
      end
      ST_HOLD: begin
        if (term_c) begin
          ifid_d.instr = NOP;
          valid_d      = 1'b0;
          state_d      = ST_HALT;
        end else if (redirect_c) begin
          pc_d         = target_c;
          ifid_d.instr = NOP;
          valid_d      = 1'b0;
          state_d      = ST_FETCH;
        end else if (!stall) begin
          ifid_d  = buf_q;
          valid_d = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        ifid_d.instr = NOP;
        valid_d      = 1'b0;
        if (term_c) begin
          halt_pend_d = 1'b1;
        end else if (redirect_c) begin
          pc_d = target_c;
        end
        if (ack_c) state_d = (halt_pend_q | term_c) ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        ifid_d.instr = NOP;
        valid_d      = 1'b0;
      end
      default: state_d = ST_FETCH;
    endcase

    // A drained request keeps its old address; a fresh fetch always targets pc
    req_d    = (state_d == ST_FETCH) | (state_d == ST_DRAIN);
    addr_d   = (state_d == ST_FETCH) ? pc_d : addr_q;
    halted_d = (state_d == ST_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ifid_q      <= '{instr: NOP, pc_plus4: RESET_PC};
      valid_q     <= 1'b0;
      buf_q       <= '0;
      halt_pend_q <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      valid_q     <= valid_d;
      buf_q       <= buf_d;
      halt_pend_q <= halt_pend_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      halted_q    <= halted_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instruction = ifid_q.instr;
  assign pc_plus4    = ifid_q.pc_plus4;
  assign valid       = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory model, reactive decode driver, scoreboard of delivered instructions.
module tb_if_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump_taken = 1'b0;
  logic [31:0] branch_offset = '0;
  logic [31:0] jump_address = '0;
  logic        terminate = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        halted;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_deliv = 0;
  exp_t        exp_q[$];
  logic [31:0] cur_pc4 = 32'd4;
  int          mem_mode = 0;
  int          mem_wait = 0;
  logic        force_ack = 1'b0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .jump_taken(jump_taken), .branch_offset(branch_offset), .jump_address(jump_address),
    .terminate(terminate), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
    .pc_plus4(pc_plus4), .valid(valid), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory contents: a bijective scramble of the address so every word is distinct
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int pick_wait();
    if (mem_mode == 0) return 0;
    if (mem_mode == 1) return 2;
    return int'($urandom_range(0, 2));
  endfunction

  assign imem_ack   = force_ack | (imem_req & (mem_wait == 0));
  assign imem_rdata = force_ack ? 32'hDEAD_BEEF : mem_word(imem_addr);

  // Wait-state counter for the request currently presented
  always @(posedge clk or negedge rst) begin
    if (!rst) mem_wait <= 0;
    else if (imem_req && imem_ack) mem_wait <= pick_wait();
    else if (imem_req && mem_wait != 0) mem_wait <= mem_wait - 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One decode cycle: drive inputs, record the expected next delivery, advance to edge+1
  task automatic step(input logic st, input logic br, input logic jp, input logic tm,
                      input logic [31:0] off, input logic [31:0] ja);
    logic        take;
    logic [31:0] n;
    logic [31:0] sx;
    exp_t        e;
    take          = valid && !st;
    stall         = st;
    branch_taken  = br & take;
    jump_taken    = jp & take;
    terminate     = tm & take;
    branch_offset = off;
    jump_address  = ja;
    if (take && !tm) begin
      sx = {{16{off[15]}}, off[15:0]};
      if (jp)      n = (cur_pc4 & 32'hF000_0000) | ((ja & 32'h03FF_FFFF) * 32'd4);
      else if (br) n = cur_pc4 + sx * 32'd4;
      else         n = cur_pc4;
      e.instr = mem_word(n);
      e.pc4   = n + 32'd4;
      exp_q.push_back(e);
      cur_pc4 = n + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    rst = 1'b0;
    #1;
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    stall = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0; terminate = 1'b0;
    exp_q.delete();
    e.instr = mem_word(32'h0);
    e.pc4   = 32'h4;
    exp_q.push_back(e);
    cur_pc4 = 32'h4;
    @(negedge clk);
    rst = 1'b1;
    force_ack = 1'b1;
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    chk("stale_ack_valid", 32'(valid), 32'd0);
    chk("stale_ack_instr", instruction, 32'h0);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
  endtask

  // Monitor: request stability and in-order comparison of every consumed IF/ID entry
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (prev_pend) begin
          chk("req_held", 32'(imem_req), 32'd1);
          chk("addr_held", imem_addr, prev_addr);
        end
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
        if (valid && !stall) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_delivery: got instr %h pc_plus4 %h, expected none", instruction, pc_plus4);
          end else begin
            chk("sb_instr", instruction, exp_q[0].instr);
            chk("sb_pc_plus4", pc_plus4, exp_q[0].pc4);
            void'(exp_q.pop_front());
            n_deliv++;
          end
        end
      end else begin
        prev_pend = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    #3;
    do_reset();

    // Zero-wait sequential fetch, then a 3-cycle stall at the ack of addr 8
    mem_mode = 0;
    step(0, 0, 0, 0, 0, 0);
    chk("seq_valid0", 32'(valid), 32'd1);
    chk("seq_pc4_0", pc_plus4, 32'h4);
    step(0, 0, 0, 0, 0, 0);
    chk("seq_valid1", 32'(valid), 32'd1);
    chk("seq_pc4_1", pc_plus4, 32'h8);
    chk("seq_addr8", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_frozen_pc4", pc_plus4, 32'h8);
      chk("hold_valid", 32'(valid), 32'd1);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("unhold_pc4", pc_plus4, 32'hC);
    chk("unhold_valid", 32'(valid), 32'd1);
    chk("no_refetch_addr", imem_addr, 32'hC);

    // Backward branch from pc_plus4 = 0x10
    step(0, 0, 0, 0, 0, 0);
    chk("br_pre_pc4", pc_plus4, 32'h10);
    step(0, 1, 0, 0, 32'h0000_FFFE, 0);
    chk("br_addr", imem_addr, 32'h8);
    chk("br_bubble", 32'(valid), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("br_one_bubble", 32'(valid), 32'd1);

    // Jump while a 2-wait-state fetch is outstanding
    mem_mode = 1;
    repeat (6) step(0, 0, 0, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (valid) found = 1'b1;
      else step(0, 0, 0, 0, 0, 0);
    end
    chk("jmp_pre_valid", 32'(found), 32'd1);
    chk("jmp_pre_outstanding", 32'(imem_req & ~imem_ack), 32'd1);
    step(0, 0, 1, 0, 0, 32'h40);
    chk("jmp_bubble", 32'(valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (imem_req && imem_addr == 32'h100) found = 1'b1;
      else step(0, 0, 0, 0, 0, 0);
    end
    chk("jmp_new_addr", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (valid) found = 1'b1;
      else step(0, 0, 0, 0, 0, 0);
    end
    chk("jmp_delivered", 32'(found), 32'd1);
    chk("jmp_pc4", pc_plus4, 32'h104);

    // Randomized traffic: wait states, stalls, branches and jumps
    mem_mode = 2;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      step($urandom_range(0, 3) == 0, r == 0, r == 1, 0, $urandom, $urandom);
    end

    // Terminate with a request outstanding
    mem_mode = 1;
    repeat (8) step(0, 0, 0, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (valid) found = 1'b1;
      else step(0, 0, 0, 0, 0, 0);
    end
    chk("term_pre_valid", 32'(found), 32'd1);
    chk("term_pre_outstanding", 32'(imem_req & ~imem_ack), 32'd1);
    step(0, 0, 0, 1, 0, 0);
    chk("term_drain_req", 32'(imem_req), 32'd1);
    chk("term_drain_not_halted", 32'(halted), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (halted) found = 1'b1;
      else step(0, 0, 0, 0, 0, 0);
    end
    chk("term_halted", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 0, $urandom, $urandom);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_valid", 32'(valid), 32'd0);
      chk("halt_flag", 32'(halted), 32'd1);
    end
    chk("halt_queue_empty", 32'(exp_q.size()), 32'd0);

    // Restart from halt
    do_reset();
    mem_mode = 0;
    step(0, 0, 0, 0, 0, 0);
    chk("restart_pc4", pc_plus4, 32'h4);
    chk("restart_valid", 32'(valid), 32'd1);

    // Reset in the middle of an outstanding request
    mem_mode = 1;
    repeat (6) step(0, 0, 0, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (imem_req && !imem_ack) found = 1'b1;
      else step(0, 0, 0, 0, 0, 0);
    end
    chk("midreq_outstanding", 32'(found), 32'd1);
    #3;
    do_reset();

    mem_mode = 2;
    for (int i = 0; i < 100; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      step($urandom_range(0, 3) == 0, r == 0, r == 1, 0, $urandom, $urandom);
    end
    chk("delivery_count_ok", 32'(n_deliv >= 60), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
